// File: rtl/qspi_flash_reader_if.sv
// qspi_flash_reader_if
//   Request/response channel between a core fetch/load port and the quad-I/O
//   flash reader. The master (core side) issues a 24-bit read address. The
//   slave (reader) returns one 32-bit word.
//
//   req_valid   master -> slave  read request
//   req_ready   slave  -> master reader is idle; transfer on valid && ready
//   req_addr    master -> slave  24-bit flash byte address
//   resp_valid  slave  -> master one-cycle pulse, resp_data valid
//   resp_data   slave  -> master read word, held until the next resp_valid
interface qspi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader
//   Initiator for the quad-I/O fast read command (0xEB) to an external QSPI
//   NOR flash. It uses SPI mode 0, so SCK idles low. One accepted request
//   produces one chip-select window. The window carries 8 command bits on
//   IO0, 6 address nibbles, 2 mode nibbles and DUMMY_CYC dummy clocks. It
//   then captures 8 data nibbles and returns them as one little-endian
//   32-bit word.
//
//   Every pad output is a flop. The outputs change only on the clk edge
//   that drives SCK low, and on the accept edge. The flash shifts data on
//   falling SCK, and the reader samples qspi_io_i on that same clk edge.
//
// Parameters
//   CLK_DIV    SCK half-period in clk cycles (>= 1)
//   MODE_BYTE  mode byte sent after the address; [7:4] must be 4'hF
//   DUMMY_CYC  dummy SCK cycles between mode and data (0..8)
//   CS_DESEL   minimum clk cycles CS stays high between transactions
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   bus          slave side of qspi_flash_reader_if (request/response)
//   qspi_io_i    data from the flash pads
//   qspi_io_o    data to the flash pads
//   qspi_io_t    per-bit tristate enable, 1 = released (input)
//   qspi_ck_o    SCK
//   qspi_cs_o    chip select, active low
module qspi_flash_reader #(
  parameter int         CLK_DIV   = 1,
  parameter logic [7:0] MODE_BYTE = 8'hF0,
  parameter int         DUMMY_CYC = 4,
  parameter int         CS_DESEL  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  qspi_flash_reader_if.slave        bus,
  input  logic [3:0]                qspi_io_i,
  output logic [3:0]                qspi_io_o,
  output logic [3:0]                qspi_io_t,
  output logic                      qspi_ck_o,
  output logic                      qspi_cs_o
);

  localparam logic [7:0] CMD_BYTE = 8'hEB;

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [2:0]       DUMMY_LAST = 3'(DUMMY_CYC - 1);
  localparam logic [7:0]       DESEL_LAST = (CS_DESEL > 1) ? 8'(CS_DESEL - 1) : 8'd0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_MODE  = 3'd3;
  localparam logic [2:0] S_DUMMY = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_DESEL = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       sck_q, sck_d;
  logic [7:0]       desel_q, desel_d;
  logic [23:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             ck_q, ck_d;
  logic             cs_q, cs_d;
  logic [3:0]       io_o_q, io_o_d;
  logic [3:0]       io_t_q, io_t_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;

  logic        last_div;
  logic        sck_fall;
  logic [31:0] nib_word;

  // The divider wraps once per SCK half-period.
  // The wrap with SCK high is the falling edge.
  assign last_div = (div_q == DIV_LAST);
  assign sck_fall = last_div && ck_q;

  // Nibbles arrive n0 first. They build up big-endian here and are
  // byte-swapped on the way out.
  assign nib_word = {data_q[27:0], qspi_io_i};

  // Next-state logic for the whole transfer. Each falling SCK edge
  // advances one bit slot. It drives the pads for the next slot: either
  // the next bit of the current phase, or the first bit of the next phase.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    sck_d        = sck_q;
    desel_d      = desel_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ck_d         = ck_q;
    cs_d         = cs_q;
    io_o_d       = io_o_q;
    io_t_d       = io_t_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_CMD;
          addr_d  = bus.req_addr;
          div_d   = '0;
          sck_d   = '0;
          cs_d    = 1'b0;
          ck_d    = 1'b0;
          // Only IO0 is driven during the command. IO2/IO3 (WP#/HOLD#)
          // are held high.
          io_t_d  = 4'b1110;
          io_o_d  = {3'b111, CMD_BYTE[7]};
        end
      end

      S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
        div_d = last_div ? '0 : div_q + DIV_ONE;
        if (last_div && !ck_q) begin
          ck_d = 1'b1;
        end
        if (sck_fall) begin
          ck_d  = 1'b0;
          sck_d = sck_q + 3'd1;
          case (state_q)
            S_CMD: begin
              if (sck_q == 3'd7) begin
                state_d = S_ADDR;
                sck_d   = '0;
                io_t_d  = 4'h0;
                io_o_d  = addr_q[23:20];
                addr_d  = {addr_q[19:0], 4'h0};
              end else begin
                io_o_d = {3'b111, CMD_BYTE[3'd6 - sck_q]};
              end
            end
            // The address shifts left so the next nibble is always on top.
            S_ADDR: begin
              if (sck_q == 3'd5) begin
                state_d = S_MODE;
                sck_d   = '0;
                io_o_d  = MODE_BYTE[7:4];
              end else begin
                io_o_d = addr_q[23:20];
                addr_d = {addr_q[19:0], 4'h0};
              end
            end
            S_MODE: begin
              if (sck_q == 3'd1) begin
                state_d = (DUMMY_CYC > 0) ? S_DUMMY : S_DATA;
                sck_d   = '0;
                io_t_d  = 4'hF;
                io_o_d  = 4'h0;
              end else begin
                io_o_d = MODE_BYTE[3:0];
              end
            end
            S_DUMMY: begin
              if (sck_q == DUMMY_LAST) begin
                state_d = S_DATA;
                sck_d   = '0;
              end
            end
            S_DATA: begin
              data_d = nib_word;
              // The last nibble closes the transaction on this same edge.
              if (sck_q == 3'd7) begin
                state_d      = S_DESEL;
                sck_d        = '0;
                desel_d      = '0;
                cs_d         = 1'b1;
                io_t_d       = 4'hF;
                io_o_d       = 4'h0;
                resp_valid_d = 1'b1;
                resp_data_d  = {nib_word[7:0], nib_word[15:8],
                                nib_word[23:16], nib_word[31:24]};
              end
            end
            default: ;
          endcase
        end
      end

      // Counts CS-high cycles before a new request can be accepted.
      S_DESEL: begin
        if (desel_q == DESEL_LAST) begin
          state_d = S_IDLE;
          desel_d = '0;
        end else begin
          desel_d = desel_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and pad registers. Reset returns the pads to the deselected,
  // released state immediately, even in the middle of a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      sck_q        <= '0;
      desel_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      ck_q         <= 1'b0;
      cs_q         <= 1'b1;
      io_o_q       <= 4'h0;
      io_t_q       <= 4'hF;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sck_q        <= sck_d;
      desel_q      <= desel_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ck_q         <= ck_d;
      cs_q         <= cs_d;
      io_o_q       <= io_o_d;
      io_t_q       <= io_t_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign qspi_io_o      = io_o_q;
  assign qspi_io_t      = io_t_q;
  assign qspi_ck_o      = ck_q;
  assign qspi_cs_o      = cs_q;

endmodule
